// File: rtl/write_address_sequencer.sv
// Write-side frame sequencer: fills DEPTH words at addresses 0..DEPTH-1 after init,
// hands the frame to the reader (full_o/done_o) and waits for release_i.
module write_address_sequencer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 5,
  parameter int ADD_W  = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              init,
  input  logic              WE,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic [ADD_W-1:0]  wr_add_o,
  output logic              full_o,
  output logic              done_o,
  input  logic              release_i,
  input  logic [ADD_W-1:0]  rd_add_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  localparam logic [ADD_W-1:0] LAST_ADD = ADD_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [ADD_W-1:0]  wr_add_q, wr_add_d;
  logic              done_q, done_d;
  logic              accept;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // init inside FILL restarts the frame and suppresses any write on that cycle
  always_comb begin
    state_d  = state_q;
    wr_add_d = wr_add_q;
    done_d   = 1'b0;
    accept   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (init) begin
          state_d  = S_FILL;
          wr_add_d = '0;
        end
      end
      S_FILL: begin
        if (init) begin
          wr_add_d = '0;
        end else if (WE) begin
          accept = 1'b1;
          if (wr_add_q == LAST_ADD) begin
            state_d  = S_FULL;
            wr_add_d = '0;
            done_d   = 1'b1;
          end else begin
            wr_add_d = wr_add_q + ADD_W'(1);
          end
        end
      end
      S_FULL: begin
        if (release_i) begin
          state_d  = init ? S_FILL : S_IDLE;
          wr_add_d = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        wr_add_d = '0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (accept && (wr_add_q == ADD_W'(i))) mem_d[i] = data_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      wr_add_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_add_q <= wr_add_d;
      done_q   <= done_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Addresses at or beyond DEPTH have no backing word and read as zero
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_add_i == ADD_W'(i)) rd_data_o = mem_q[i];
    end
  end

  assign ready_o  = (state_q == S_FILL);
  assign full_o   = (state_q == S_FULL);
  assign done_o   = done_q;
  assign wr_add_o = wr_add_q;

endmodule

// File: tb/tb_write_address_sequencer.sv
// Randomised self-checking bench for write_address_sequencer against a frame-level model.
module tb_write_address_sequencer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 5;
  localparam int ADD_W  = 3;
  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_FULL = 2;

  logic              CLK = 1'b0;
  logic              RST_N, init, WE, release_i;
  logic [DATA_W-1:0] data_i;
  logic [ADD_W-1:0]  rd_add_i;
  logic              ready_o, full_o, done_o;
  logic [ADD_W-1:0]  wr_add_o;
  logic [DATA_W-1:0] rd_data_o;

  write_address_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADD_W(ADD_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .init(init), .WE(WE), .data_i(data_i),
    .ready_o(ready_o), .wr_add_o(wr_add_o), .full_o(full_o), .done_o(done_o),
    .release_i(release_i), .rd_add_i(rd_add_i), .rd_data_o(rd_data_o)
  );

  always #10 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  // Frame-level model: mode, words written so far in this frame, buffer contents
  int                m_mode;
  int                m_count;
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic              m_done;

  task automatic model_edge();
    m_done = 1'b0;
    if (!RST_N) begin
      m_mode  = M_IDLE;
      m_count = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (m_mode == M_IDLE) begin
      if (init) begin m_mode = M_FILL; m_count = 0; end
    end else if (m_mode == M_FILL) begin
      if (init) m_count = 0;
      else if (WE) begin
        m_mem[m_count] = data_i;
        m_count++;
        if (m_count == DEPTH) begin m_mode = M_FULL; m_count = 0; m_done = 1'b1; end
      end
    end else if (release_i) begin
      m_mode  = init ? M_FILL : M_IDLE;
      m_count = 0;
    end
  endtask

  task automatic drive(input logic rst_n_v, input logic init_v, input logic we_v,
                       input logic rel_v, input logic [DATA_W-1:0] d);
    RST_N = rst_n_v; init = init_v; WE = we_v; release_i = rel_v; data_i = d;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic fill_frame();
    drive(1, 1, 0, 0, 8'h00); tick();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 1, 0, 8'($urandom)); tick();
    end
    drive(1, 0, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    drive(0, 0, 1, 0, 8'hAA); tick(); tick();
    n_total++;
    if ({ready_o, full_o, done_o, wr_add_o} !== 6'b0) begin
      $display("FAIL reset_ctrl: got %b want 000000", {ready_o, full_o, done_o, wr_add_o});
    end else n_pass++;
    drive(1, 0, 1, 0, 8'hAA); tick(); tick();
    n_total++;
    if ({ready_o, full_o, done_o, wr_add_o} !== 6'b0) begin
      $display("FAIL idle_ignores_we: got %b want 000000", {ready_o, full_o, done_o, wr_add_o});
    end else n_pass++;
    for (int a = 0; a < 8; a++) begin
      rd_add_i = 3'(a); #1;
      n_total++;
      if (rd_data_o !== 8'h00) $display("FAIL reset_read[%0d]: got %h want 00", a, rd_data_o);
      else n_pass++;
    end
  endtask

  task automatic test_full_frame();
    int done_cnt;
    done_cnt = 0;
    drive(1, 1, 0, 0, 8'h00); tick();
    for (int i = 0; i < DEPTH; i++) begin
      n_total++;
      if (wr_add_o !== 3'(i) || ready_o !== 1'b1) begin
        $display("FAIL frame_addr[%0d]: got addr=%0d ready=%b want addr=%0d ready=1", i, wr_add_o, ready_o, i);
      end else n_pass++;
      drive(1, 0, 1, 0, 8'(8'h11 * (i + 1))); tick();
      if (done_o) done_cnt++;
      n_total++;
      if ({ready_o, full_o, done_o, wr_add_o} !== {m_mode == M_FILL, m_mode == M_FULL, m_done, 3'(m_count)}) begin
        $display("FAIL frame_ctrl[%0d]: got %b want %b", i, {ready_o, full_o, done_o, wr_add_o},
                 {m_mode == M_FILL, m_mode == M_FULL, m_done, 3'(m_count)});
      end else n_pass++;
    end
    drive(1, 0, 0, 0, 8'h00); tick();
    if (done_o) done_cnt++;
    n_total++;
    if (done_cnt != 1 || full_o !== 1'b1 || wr_add_o !== 3'd0) begin
      $display("FAIL frame_done: got done_cycles=%0d full=%b addr=%0d want 1 1 0", done_cnt, full_o, wr_add_o);
    end else n_pass++;
    for (int a = 0; a < 8; a++) begin
      rd_add_i = 3'(a); #1;
      n_total++;
      if (rd_data_o !== ((a < DEPTH) ? 8'(8'h11 * (a + 1)) : 8'h00)) begin
        $display("FAIL frame_read[%0d]: got %h want %h", a, rd_data_o, (a < DEPTH) ? 8'(8'h11 * (a + 1)) : 8'h00);
      end else n_pass++;
    end
  endtask

  task automatic test_gapped();
    drive(1, 1, 0, 1, 8'h00); tick();
    for (int c = 0; c < 2 * DEPTH; c++) begin
      drive(1, 0, (c % 2) == 0, 0, 8'($urandom)); tick();
      n_total++;
      if ({ready_o, full_o, done_o, wr_add_o} !== {m_mode == M_FILL, m_mode == M_FULL, m_done, 3'(m_count)}) begin
        $display("FAIL gapped_ctrl[%0d]: got %b want %b", c, {ready_o, full_o, done_o, wr_add_o},
                 {m_mode == M_FILL, m_mode == M_FULL, m_done, 3'(m_count)});
      end else n_pass++;
    end
    for (int a = 0; a < 8; a++) begin
      rd_add_i = 3'(a); #1;
      n_total++;
      if (rd_data_o !== ((a < DEPTH) ? m_mem[a] : 8'h00)) begin
        $display("FAIL gapped_read[%0d]: got %h want %h", a, rd_data_o, (a < DEPTH) ? m_mem[a] : 8'h00);
      end else n_pass++;
    end
  endtask

  task automatic test_frozen_release();
    fill_frame(); tick();
    drive(1, 1, 1, 0, 8'hFF); tick();
    n_total++;
    if (full_o !== 1'b1 || ready_o !== 1'b0) begin
      $display("FAIL frozen_ctrl: got full=%b ready=%b want 1 0", full_o, ready_o);
    end else n_pass++;
    for (int a = 0; a < DEPTH; a++) begin
      rd_add_i = 3'(a); #1;
      n_total++;
      if (rd_data_o !== m_mem[a]) $display("FAIL frozen_read[%0d]: got %h want %h", a, rd_data_o, m_mem[a]);
      else n_pass++;
    end
    drive(1, 0, 0, 1, 8'h00); tick();
    n_total++;
    if (full_o !== 1'b0 || ready_o !== 1'b0) begin
      $display("FAIL release_idle: got full=%b ready=%b want 0 0", full_o, ready_o);
    end else n_pass++;
    fill_frame(); tick();
    drive(1, 1, 0, 1, 8'h00); tick();
    n_total++;
    if (full_o !== 1'b0 || ready_o !== 1'b1 || wr_add_o !== 3'd0) begin
      $display("FAIL release_init: got full=%b ready=%b addr=%0d want 0 1 0", full_o, ready_o, wr_add_o);
    end else n_pass++;
  endtask

  task automatic test_restart();
    drive(1, 1, 0, 0, 8'h00); tick();
    drive(1, 0, 1, 0, 8'h01); tick();
    drive(1, 0, 1, 0, 8'h02); tick();
    n_total++;
    if (wr_add_o !== 3'd2) $display("FAIL restart_pre_addr: got %0d want 2", wr_add_o);
    else n_pass++;
    drive(1, 1, 1, 0, 8'h99); tick();
    n_total++;
    if (wr_add_o !== 3'd0 || ready_o !== 1'b1) begin
      $display("FAIL restart_addr: got addr=%0d ready=%b want 0 1", wr_add_o, ready_o);
    end else n_pass++;
    rd_add_i = 3'd2; #1;
    n_total++;
    if (rd_data_o !== m_mem[2] || rd_data_o === 8'h99) begin
      $display("FAIL restart_no_write: got %h want %h", rd_data_o, m_mem[2]);
    end else n_pass++;
    drive(1, 0, 1, 0, 8'h77); tick();
    rd_add_i = 3'd0; #1;
    n_total++;
    if (rd_data_o !== 8'h77 || wr_add_o !== 3'd1) begin
      $display("FAIL restart_write: got data=%h addr=%0d want 77 1", rd_data_o, wr_add_o);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    int done_seen;
    done_seen = 0;
    drive(1, 1, 0, 0, 8'h00); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 8'($urandom | 1)); tick();
    end
    drive(0, 0, 1, 0, 8'h5A); tick();
    n_total++;
    if ({ready_o, full_o, done_o, wr_add_o} !== 6'b0) begin
      $display("FAIL midreset_ctrl: got %b want 000000", {ready_o, full_o, done_o, wr_add_o});
    end else n_pass++;
    for (int a = 0; a < 8; a++) begin
      rd_add_i = 3'(a); #1;
      n_total++;
      if (rd_data_o !== 8'h00) $display("FAIL midreset_read[%0d]: got %h want 00", a, rd_data_o);
      else n_pass++;
    end
    drive(1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_o) done_seen++;
    end
    n_total++;
    if (done_seen != 0 || ready_o !== 1'b0) begin
      $display("FAIL midreset_done: got done_cycles=%0d ready=%b want 0 0", done_seen, ready_o);
    end else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 59) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0, 8'($urandom));
      rd_add_i = 3'($urandom_range(0, 7));
      tick();
      n_total++;
      if ({ready_o, full_o, done_o, wr_add_o} !== {m_mode == M_FILL, m_mode == M_FULL, m_done, 3'(m_count)}) begin
        $display("FAIL random_ctrl[%0d]: got %b want %b", c, {ready_o, full_o, done_o, wr_add_o},
                 {m_mode == M_FILL, m_mode == M_FULL, m_done, 3'(m_count)});
      end else n_pass++;
      n_total++;
      if (rd_data_o !== ((rd_add_i < DEPTH) ? m_mem[rd_add_i] : 8'h00)) begin
        $display("FAIL random_read[%0d]: addr=%0d got %h want %h", c, rd_add_i, rd_data_o,
                 (rd_add_i < DEPTH) ? m_mem[rd_add_i] : 8'h00);
      end else n_pass++;
    end
  endtask

  initial begin
    rd_add_i = '0;
    m_mode = M_IDLE; m_count = 0; m_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    drive(0, 0, 0, 0, 8'h00);
    @(negedge CLK);
    test_reset();
    test_full_frame();
    test_gapped();
    test_frozen_release();
    test_restart();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
